fifo_drain: RTL
===============

Name: fifo_drain

Overview:
Read-side consumer for the team's byte FIFO. Runs in the FIFO read-clock domain and drives the FIFO read port (rd/empty/data_out). Pulls bytes at up to one per cycle and presents them on a valid/ready stream with frame markers and a transfer counter. A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency and downstream back-pressure without dropping or duplicating bytes.

Parameters:
width, 8, data width; must match the FIFO width.
frame_len, 8, bytes per frame; out_last marks byte frame_len-1. Legal range is 1 to 2^frame_width.
frame_width, 3, width of the in-frame index counter (ceil(log_2(frame_len))).

Ports:
rd_clk  input  1  clock; same clock as the FIFO read port.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = issue new FIFO reads; 0 = stop issuing, finish in-flight work.
fifo_empty  input  1  FIFO empty flag; treated as synchronous to rd_clk.
fifo_data  input  width  FIFO data_out; valid the cycle after fifo_rd.
fifo_rd  output  1  FIFO read enable; one byte per asserted cycle.
out_data  output  width  head byte of the skid buffer.
out_valid  output  1  out_data holds a valid byte.
out_ready  input  1  downstream accepts the byte; transfer = out_valid & out_ready.
out_last  output  1  qualified by out_valid; head byte is the last byte of its frame.
byte_count  output  16  total bytes transferred since reset; wraps 0xFFFF->0.
busy  output  1  any byte is buffered or a read is in flight.

Behaviour:
- Reset (async assert; release is taken on rd_clk):
  - fifo_rd=0, out_valid=0, out_data=0, out_last=0, byte_count=0, busy=0.
  - Skid buffer emptied, in-flight flag cleared, frame index cleared to 0.
- State:
  - occ: buffer occupancy, 0..2.
  - inflight: the registered value of last cycle's fifo_rd.
  - idx: in-frame index, 0..frame_len-1.
- Read issue (combinational, registered into inflight):
  - fifo_rd = enable & !fifo_empty & ((occ + inflight - pop) < 2), where pop = out_valid & out_ready.
  - Invariant: occ + inflight <= 2 at all times.
- Capture:
  - When inflight=1, fifo_data is written into the buffer tail at that clock edge.
  - Capture and pop in the same cycle leave occ unchanged; order is preserved, FIFO first in first out.
- Output:
  - out_valid = (occ != 0).
  - out_data is the oldest entry and is held stable while out_valid=1 and out_ready=0.
  - Latency: fifo_rd at cycle N -> captured at the end of N+1 -> out_valid=1 in cycle N+2.
- Throughput:
  - With !fifo_empty, enable=1 and out_ready=1 held, fifo_rd stays high every cycle after startup.
  - One byte transfers per cycle with no bubbles.
- Back-pressure:
  - out_ready=0 with occ=2 forces fifo_rd=0.
  - When out_ready returns, streaming resumes with no loss.
- Framing:
  - out_last = out_valid & (idx == frame_len-1).
  - On each transfer, idx increments, wrapping to 0 after frame_len-1.
  - frame_len=1 makes out_last=1 on every byte.
  - idx counts transferred bytes, not read bytes.
- byte_count increments by 1 per transfer, modulo 2^16.
- busy = (occ != 0) | inflight.
- enable deasserted mid-stream:
  - fifo_rd drops in the same cycle.
  - The in-flight byte is still captured, and buffered bytes are still delivered.
  - idx is preserved; frames continue across enable gaps.
- fifo_empty rising mid-stream: fifo_rd drops in the same cycle; no read is issued while fifo_empty=1.
- Reset mid-operation: buffered and in-flight bytes are discarded; idx and byte_count return to 0.

Test Plan:
1. Reset then fill the FIFO with 0x10..0x17, enable=1, out_ready=1 -> fifo_rd high for 8 consecutive cycles; out_valid first rises 2 cycles after the first fifo_rd; out_data 0x10..0x17 on consecutive cycles; out_last only with 0x17; byte_count=8.
2. Stream 0xA0..0xA5 while holding out_ready=0 for cycles 4-9 -> fifo_rd drops once occ=2; out_data holds 0xA0 stable; after release the sequence resumes 0xA1..0xA5 with no gaps, duplicates or loss.
3. frame_len=3, stream 7 bytes -> out_last asserted on bytes 3 and 6 only; idx=1 afterwards.
4. Stream 0x30..0x33, drop enable after the second fifo_rd -> exactly 2 bytes (0x30, 0x31) delivered; busy returns to 0; re-enabling delivers 0x32, 0x33 with out_last continuing the same frame count.
5. fifo_empty toggling every other cycle with 5 bytes queued -> fifo_rd is never high while fifo_empty=1; all 5 bytes arrive in order.
6. Assert reset with occ=2 and inflight=1 -> out_valid=0, busy=0, byte_count=0 immediately; after release the first new byte has idx 0.

Source files
------------

// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain
// Description : Read-side consumer for the byte FIFO. Pulls bytes through a
//               2-entry skid buffer onto a valid/ready stream with frame
//               markers and a running transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain #(
    parameter int WIDTH       = 8,
    parameter int FRAME_LEN   = 8,
    parameter int FRAME_WIDTH = 3
) (
    input  logic             rd_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [15:0]      byte_count,
    output logic             busy
);

    // A single-byte frame needs no index bits; keep the counter one bit wide.
    localparam int                  c_IDX_W    = (FRAME_WIDTH < 1) ? 1 : FRAME_WIDTH;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(FRAME_LEN - 1);

    logic [1:0]         r_occ;
    logic               r_inflight;
    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   r_tail;
    logic [c_IDX_W-1:0] r_idx;
    logic [15:0]        r_byte_count;

    logic               w_pop;
    logic [2:0]         w_level;
    logic [1:0]         w_occ_nxt;
    logic [WIDTH-1:0]   w_head_nxt;
    logic [WIDTH-1:0]   w_tail_nxt;

    assign out_valid  = (r_occ != 2'd0);
    assign out_data   = r_head;
    assign out_last   = out_valid & (r_idx == c_LAST_IDX);
    assign byte_count = r_byte_count;
    assign busy       = (r_occ != 2'd0) | r_inflight;

    assign w_pop   = out_valid & out_ready;
    // Slots committed after this edge; a pop always has occ >= 1, so no underflow.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd = enable & ~fifo_empty & ~reset & (w_level < 3'd2);

    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        case ({r_inflight, w_pop})
            2'b10: begin
                w_occ_nxt = r_occ + 2'd1;
                if (r_occ == 2'd0) begin
                    w_head_nxt = fifo_data;
                end else begin
                    w_tail_nxt = fifo_data;
                end
            end
            2'b01: begin
                w_occ_nxt  = r_occ - 2'd1;
                w_head_nxt = r_tail;
            end
            2'b11: begin
                if (r_occ == 2'd1) begin
                    w_head_nxt = fifo_data;
                end else begin
                    w_head_nxt = r_tail;
                    w_tail_nxt = fifo_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            r_occ        <= 2'd0;
            r_inflight   <= 1'b0;
            r_head       <= '0;
            r_tail       <= '0;
            r_idx        <= '0;
            r_byte_count <= 16'd0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_inflight <= fifo_rd;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            // Frame position follows accepted bytes, so it survives enable gaps.
            if (w_pop) begin
                r_idx        <= (r_idx == c_LAST_IDX) ? '0 : r_idx + c_IDX_W'(1);
                r_byte_count <= r_byte_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
